// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

   typedef enum logic {
      UNCFG = 1'b0,
      ARMED = 1'b1
   } state_t;

   function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
      return (len != 0) && (len <= max_len);
   endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter: clear wins over increment; holds at all-ones instead of wrapping.
module seq_det_match_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/pattern_seq_detector.sv
// Runtime-programmable serial pattern detector; match is a registered pulse one cycle after the completing bit.
// Define SEQ_DET_CNT_EN to build the saturating match counter, otherwise match_count is tied to 0.
module pattern_seq_detector
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               in_valid,
   input  logic               x,
   output logic               armed,
   output logic               cfg_err,
   output logic               match,
   output logic [CNT_W-1:0]   match_count
);

   state_t             r_state;
   logic [MAX_LEN-1:0] r_pattern;
   logic [LEN_W-1:0]   r_len;
   logic               r_overlap;
   logic [MAX_LEN-1:0] r_hist;
   logic [LEN_W-1:0]   r_fill;
   logic               r_match;
   logic               r_cfg_err;

   logic               w_len_ok;
   logic               w_cfg_ok;
   logic               w_accept;
   logic [MAX_LEN-1:0] w_hist_nxt;
   logic [LEN_W-1:0]   w_fill_nxt;
   logic [MAX_LEN-1:0] w_mask;
   logic               w_hit;
   logic               w_hit_acc;

   assign w_len_ok  = len_legal(32'(cfg_len), MAX_LEN);
   assign w_cfg_ok  = cfg_load && w_len_ok;
   // A same-cycle cfg_load discards the incoming bit, legal or not.
   assign w_accept  = (r_state == ARMED) && in_valid && !cfg_load;

   assign w_hist_nxt = MAX_LEN'({r_hist, x});
   assign w_fill_nxt = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
   assign w_mask     = ~({MAX_LEN{1'b1}} << r_len);
   assign w_hit      = (w_fill_nxt >= r_len) && (((w_hist_nxt ^ r_pattern) & w_mask) == '0);
   assign w_hit_acc  = w_accept && w_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= UNCFG;
         r_pattern <= '0;
         r_len     <= '0;
         r_overlap <= 1'b0;
         r_hist    <= '0;
         r_fill    <= '0;
         r_match   <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_match   <= 1'b0;
         r_cfg_err <= 1'b0;
         if (cfg_load) begin
            if (w_len_ok) begin
               r_state   <= ARMED;
               r_pattern <= cfg_pattern;
               r_len     <= cfg_len;
               r_overlap <= cfg_overlap;
               r_hist    <= '0;
               r_fill    <= '0;
            end else begin
               r_cfg_err <= 1'b1;
            end
         end else if (w_accept) begin
            r_hist  <= w_hist_nxt;
            // Non-overlap restarts the fill so the next match needs a full fresh pattern.
            r_fill  <= (w_hit && !r_overlap) ? '0 : w_fill_nxt;
            r_match <= w_hit;
         end
      end
   end

   assign armed   = (r_state == ARMED);
   assign cfg_err = r_cfg_err;
   assign match   = r_match;

`ifdef SEQ_DET_CNT_EN
   seq_det_match_cnt #(
      .CNT_W (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_cfg_ok),
      .i_inc (w_hit_acc),
      .o_cnt (match_count)
   );
`else
   assign match_count = '0;
`endif

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Directed table-driven bench for pattern_seq_detector plus a hand-written async-reset sequence.
module tb_pattern_seq_detector;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 2;
`ifdef SEQ_DET_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               cfg_load = 1'b0;
   logic [MAX_LEN-1:0] cfg_pattern = '0;
   logic [LEN_W-1:0]   cfg_len = '0;
   logic               cfg_overlap = 1'b0;
   logic               in_valid = 1'b0;
   logic               x = 1'b0;
   logic               armed;
   logic               cfg_err;
   logic               match;
   logic [CNT_W-1:0]   match_count;

   int n_tests = 0;
   int n_fail  = 0;

   pattern_seq_detector #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .in_valid    (in_valid),
      .x           (x),
      .armed       (armed),
      .cfg_err     (cfg_err),
      .match       (match),
      .match_count (match_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             ld;
      logic [7:0]       pat;
      logic [3:0]       len;
      logic             ov;
      logic             iv;
      logic             xb;
      logic             e_match;
      logic             e_armed;
      logic             e_err;
      logic [CNT_W-1:0] e_cnt;
      string            name;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic ld, input logic [7:0] pat, input logic [3:0] len, input logic ov,
                      input logic iv, input logic xb, input logic em, input logic ea,
                      input logic ee, input logic [CNT_W-1:0] ec, input string name);
      vec_t v;
      v.ld = ld; v.pat = pat; v.len = len; v.ov = ov; v.iv = iv; v.xb = xb;
      v.e_match = em; v.e_armed = ea; v.e_err = ee; v.e_cnt = ec; v.name = name;
      vecs.push_back(v);
   endtask

   // Shorthand for a data row with no cfg_load.
   task automatic bitv(input logic iv, input logic xb, input logic em, input logic ea,
                       input logic [CNT_W-1:0] ec, input string name);
      add(1'b0, 8'h00, 4'd0, 1'b0, iv, xb, em, ea, 1'b0, ec, name);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic em, input logic ea, input logic ee,
                            input logic [CNT_W-1:0] ec);
      check({name, ".match"}, 32'(match), 32'(em));
      check({name, ".armed"}, 32'(armed), 32'(ea));
      check({name, ".cfg_err"}, 32'(cfg_err), 32'(ee));
      check({name, ".count"}, 32'(match_count), CNT_EN ? 32'(ec) : 32'd0);
   endtask

   initial begin
      // T1: unconfigured, bits ignored
      bitv(1, 1, 0, 0, 0, "t1_b1");
      bitv(1, 0, 0, 0, 0, "t1_b2");
      bitv(1, 1, 0, 0, 0, "t1_b3");
      // T2: 101, non-overlap
      add(1, 8'h05, 4'd3, 0, 0, 0, 0, 1, 0, 0, "t2_load");
      bitv(1, 1, 0, 1, 0, "t2_b1");
      bitv(1, 0, 0, 1, 0, "t2_b2");
      bitv(1, 1, 1, 1, 1, "t2_b3");
      bitv(1, 0, 0, 1, 1, "t2_b4");
      bitv(1, 1, 0, 1, 1, "t2_b5");
      // T3: 101, overlap
      add(1, 8'h05, 4'd3, 1, 0, 0, 0, 1, 0, 0, "t3_load");
      bitv(1, 1, 0, 1, 0, "t3_b1");
      bitv(1, 0, 0, 1, 0, "t3_b2");
      bitv(1, 1, 1, 1, 1, "t3_b3");
      bitv(1, 0, 0, 1, 1, "t3_b4");
      bitv(1, 1, 1, 1, 2, "t3_b5");
      // T4: illegal loads keep config/history; loaded-cycle bit discarded
      add(1, 8'hFF, 4'd0, 0, 0, 0, 0, 1, 1, 2, "t4_len0");
      bitv(0, 0, 0, 1, 2, "t4_idle");
      add(1, 8'hFF, 4'd9, 0, 1, 0, 0, 1, 1, 2, "t4_len9");
      bitv(1, 0, 0, 1, 2, "t4_b1");
      bitv(1, 1, 1, 1, 3, "t4_b2");
      // T5: A5, len 8, gaps mid-pattern
      add(1, 8'hA5, 4'd8, 0, 0, 0, 0, 1, 0, 0, "t5_load");
      bitv(1, 1, 0, 1, 0, "t5_b1");
      bitv(1, 0, 0, 1, 0, "t5_b2");
      bitv(0, 1, 0, 1, 0, "t5_gap1");
      bitv(1, 1, 0, 1, 0, "t5_b3");
      bitv(1, 0, 0, 1, 0, "t5_b4");
      bitv(0, 1, 0, 1, 0, "t5_gap2");
      bitv(0, 0, 0, 1, 0, "t5_gap3");
      bitv(1, 0, 0, 1, 0, "t5_b5");
      bitv(1, 1, 0, 1, 0, "t5_b6");
      bitv(0, 1, 0, 1, 0, "t5_gap4");
      bitv(1, 0, 0, 1, 0, "t5_b7");
      bitv(1, 1, 1, 1, 1, "t5_b8");
      bitv(0, 1, 0, 1, 1, "t5_gapdrop");
      bitv(1, 0, 0, 1, 1, "t5_c1");
      bitv(1, 1, 0, 1, 1, "t5_c2");
      // T6: len 1, saturating count
      add(1, 8'h01, 4'd1, 0, 0, 0, 0, 1, 0, 0, "t6_load");
      bitv(1, 1, 1, 1, 1, "t6_b1");
      bitv(1, 1, 1, 1, 2, "t6_b2");
      bitv(1, 1, 1, 1, 3, "t6_b3");
      bitv(1, 0, 0, 1, 3, "t6_zero");
      bitv(1, 1, 1, 1, 3, "t6_b4");
      bitv(1, 1, 1, 1, 3, "t6_b5");

      repeat (2) @(posedge clk);
      #1;
      check_all("reset_hold", 0, 0, 0, 0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1;
      check_all("after_reset", 0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         cfg_load    = vecs[i].ld;
         cfg_pattern = vecs[i].pat;
         cfg_len     = vecs[i].len;
         cfg_overlap = vecs[i].ov;
         in_valid    = vecs[i].iv;
         x           = vecs[i].xb;
         @(posedge clk);
         #1;
         check_all(vecs[i].name, vecs[i].e_match, vecs[i].e_armed, vecs[i].e_err, vecs[i].e_cnt);
      end

      // Async reset while a match pulse is showing: outputs clear without a clock edge.
      @(negedge clk);
      cfg_load = 1'b0; in_valid = 1'b1; x = 1'b1;
      @(posedge clk);
      #1;
      check_all("pre_rst", 1, 1, 0, 3);
      #1 reset = 1'b1;
      #1;
      check_all("async_rst", 0, 0, 0, 0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1;
      check_all("post_rst_b1", 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check_all("post_rst_b2", 0, 0, 0, 0);

      // Legal reload drops a pending hit: the bit in the load cycle is discarded.
      @(negedge clk);
      cfg_load = 1'b1; cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1'b1;
      @(posedge clk);
      #1;
      check_all("reload_uncfg", 0, 1, 0, 0);
      @(negedge clk) cfg_load = 1'b0;
      @(posedge clk);
      #1;
      check_all("ov_len1", 1, 1, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
